time_block: RTL and testbench

Timekeeping core of the digital clock (DUT name TIME; `time` is a reserved word, so the RTL module is `time_block`). Maintains a 12-hour time of day (AM/PM, hour, minute, second) as BCD-style display digits. The seconds prescaler advances the time in run mode. In set mode, two push-button inputs select and increment individual fields. Outputs drive the display/mux logic downstream.

---
 rtl/time_block_pkg.sv | 30 +++
 rtl/time_block_bcd_mod60.sv | 48 ++++
 rtl/time_block.sv | 129 ++++++++++++
 tb/tb_time_block.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_block_pkg.sv
// Shared definitions for the timekeeping core: field pointer, reset time, digit limits.
package time_block_pkg;

  typedef enum logic [1:0] {
    FLD_HOUR = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_SEC  = 2'd2
  } field_e;

  // Time of day after reset: 12:00:00 AM
  localparam logic       RST_AMPM  = 1'b0;
  localparam logic [3:0] RST_HOUR  = 4'd12;
  localparam logic [2:0] RST_TENS  = 3'd0;
  localparam logic [3:0] RST_UNITS = 4'd0;

  // Digit limits
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;
  localparam logic [3:0] HOUR_MAX  = 4'd12;

  // Field-select order HOUR -> MIN -> SEC -> HOUR
  function automatic field_e next_field(input field_e f);
    case (f)
      FLD_HOUR: next_field = FLD_MIN;
      FLD_MIN:  next_field = FLD_SEC;
      default:  next_field = FLD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/time_block_bcd_mod60.sv
// Two-digit 00..59 counter (tens/units) with increment enable and gated carry out.
module bcd_mod60
  import time_block_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       carry_en,
  output logic [2:0] tens,
  output logic [3:0] units,
  output logic       carry_out
);

  logic [2:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  // Next digit values: units wrap 9->0 into tens, tens wrap 5->0
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (inc) begin
      if (units_q == UNITS_MAX) begin
        units_d = 4'd0;
        if (tens_q == TENS_MAX) tens_d = 3'd0;
        else                    tens_d = tens_q + 3'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous active-low reset to 00
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q  <= RST_TENS;
      units_q <= RST_UNITS;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  // Carry fires on the 59 -> 00 wrap only when the next stage is allowed to count
  assign carry_out = inc & carry_en & (units_q == UNITS_MAX) & (tens_q == TENS_MAX);
  assign tens      = tens_q;
  assign units     = units_q;

endmodule

// File: rtl/time_block.sv
// Timekeeping core: 12-hour time with seconds prescaler, run mode and button-driven set mode.
module time_block
  import time_block_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW_F1,
  input  logic       SW_F2,
  input  logic       TIMESET_RUN,
  output logic       TIM_AMPM,
  output logic [3:0] TIM_HOUR,
  output logic [2:0] TIM_MINHIGH,
  output logic [3:0] TIM_MINLOW,
  output logic [2:0] TIM_SECHIGH,
  output logic [3:0] TIM_SECLOW
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             f1_prev_q, f1_prev_d;
  logic             f2_prev_q, f2_prev_d;
  logic             mode_prev_q, mode_prev_d;
  field_e           ptr_q, ptr_d;
  logic             ampm_q, ampm_d;
  logic [3:0]       hour_q, hour_d;

  logic tick;
  logic mode_rise;
  logic set_ok;
  logic f1_evt, f2_evt;
  logic set_inc_hour, set_inc_min, set_inc_sec;
  logic sec_carry, min_carry;
  logic hour_inc;

  // Button and mode edge detection; buttons only act when set mode was already active
  always_comb begin
    mode_rise    = TIMESET_RUN & ~mode_prev_q;
    set_ok       = TIMESET_RUN & mode_prev_q;
    f1_evt       = set_ok & SW_F1 & ~f1_prev_q;
    f2_evt       = set_ok & SW_F2 & ~f2_prev_q & ~f1_evt;
    set_inc_hour = f2_evt & (ptr_q == FLD_HOUR);
    set_inc_min  = f2_evt & (ptr_q == FLD_MIN);
    set_inc_sec  = f2_evt & (ptr_q == FLD_SEC);
    f1_prev_d    = SW_F1;
    f2_prev_d    = SW_F2;
    mode_prev_d  = TIMESET_RUN;
  end

  // Prescaler: counts in run mode, held at 0 in set mode, one-cycle tick on wrap
  always_comb begin
    tick  = ~TIMESET_RUN & (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (TIMESET_RUN || tick) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  // Field pointer: reloads HOUR on entry to set mode, F1 event advances it
  always_comb begin
    ptr_d = ptr_q;
    if (mode_rise)   ptr_d = FLD_HOUR;
    else if (f1_evt) ptr_d = next_field(ptr_q);
  end

  // Hour 12 -> 1 -> ... -> 11 -> 12; AM/PM flips only when entering 12
  always_comb begin
    hour_inc = min_carry | set_inc_hour;
    hour_d   = hour_q;
    ampm_d   = ampm_q;
    if (hour_inc) begin
      if (hour_q == HOUR_MAX) begin
        hour_d = 4'd1;
      end else begin
        hour_d = hour_q + 4'd1;
        if (hour_q == HOUR_MAX - 4'd1) ampm_d = ~ampm_q;
      end
    end
  end

  // Control and hour registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q       <= '0;
      f1_prev_q   <= 1'b0;
      f2_prev_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      ptr_q       <= FLD_HOUR;
      ampm_q      <= RST_AMPM;
      hour_q      <= RST_HOUR;
    end else begin
      cnt_q       <= cnt_d;
      f1_prev_q   <= f1_prev_d;
      f2_prev_q   <= f2_prev_d;
      mode_prev_q <= mode_prev_d;
      ptr_q       <= ptr_d;
      ampm_q      <= ampm_d;
      hour_q      <= hour_d;
    end
  end

  // Seconds: carry into minutes only while running
  bcd_mod60 u_sec (
    .clk       (CLK),
    .rst_n     (RST),
    .inc       (tick | set_inc_sec),
    .carry_en  (~TIMESET_RUN),
    .tens      (TIM_SECHIGH),
    .units     (TIM_SECLOW),
    .carry_out (sec_carry)
  );

  // Minutes: carry into the hour only while running
  bcd_mod60 u_min (
    .clk       (CLK),
    .rst_n     (RST),
    .inc       (sec_carry | set_inc_min),
    .carry_en  (~TIMESET_RUN),
    .tens      (TIM_MINHIGH),
    .units     (TIM_MINLOW),
    .carry_out (min_carry)
  );

  assign TIM_AMPM = ampm_q;
  assign TIM_HOUR = hour_q;

endmodule

// File: tb/tb_time_block.sv
// Self-checking bench for time_block: directed scenarios plus randomized inputs against a time-of-day model.
module tb_time_block;

  localparam int CLK_DIV = 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SW_F1 = 1'b0;
  logic       SW_F2 = 1'b0;
  logic       TIMESET_RUN = 1'b0;
  logic       TIM_AMPM;
  logic [3:0] TIM_HOUR;
  logic [2:0] TIM_MINHIGH;
  logic [3:0] TIM_MINLOW;
  logic [2:0] TIM_SECHIGH;
  logic [3:0] TIM_SECLOW;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: seconds since midnight, field index 0=hour 1=min 2=sec
  int   m_secs  = 0;
  int   m_presc = 0;
  int   m_ptr   = 0;
  logic m_pf1   = 1'b0;
  logic m_pf2   = 1'b0;
  logic m_pmode = 1'b0;

  time_block #(.CLK_DIV(CLK_DIV)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SW_F1       (SW_F1),
    .SW_F2       (SW_F2),
    .TIMESET_RUN (TIMESET_RUN),
    .TIM_AMPM    (TIM_AMPM),
    .TIM_HOUR    (TIM_HOUR),
    .TIM_MINHIGH (TIM_MINHIGH),
    .TIM_MINLOW  (TIM_MINLOW),
    .TIM_SECHIGH (TIM_SECHIGH),
    .TIM_SECLOW  (TIM_SECLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [18:0] disp(input int s);
    int h24, h12, m, sec;
    logic pm;
    h24 = s / 3600;
    m   = (s / 60) % 60;
    sec = s % 60;
    pm  = (h24 >= 12);
    h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    return {pm, 4'(h12), 3'(m / 10), 4'(m % 10), 3'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [18:0] mk(input logic pm, input int h, input int m, input int sec);
    return disp(((h % 12) + (pm ? 12 : 0)) * 3600 + m * 60 + sec);
  endfunction

  function automatic logic [18:0] obs();
    return {TIM_AMPM, TIM_HOUR, TIM_MINHIGH, TIM_MINLOW, TIM_SECHIGH, TIM_SECLOW};
  endfunction

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply the spec's rules to the model for one clock edge
  task automatic model_step(input logic r, input logic f1, input logic f2, input logic md);
    logic e1, e2, rise;
    int h, mi, se;
    if (!r) begin
      m_secs = 0; m_presc = 0; m_ptr = 0;
      m_pf1 = 1'b0; m_pf2 = 1'b0; m_pmode = 1'b0;
      return;
    end
    e1   = f1 && !m_pf1;
    e2   = f2 && !m_pf2;
    rise = md && !m_pmode;
    if (!md) begin
      if (m_presc == CLK_DIV - 1) begin
        m_presc = 0;
        m_secs  = (m_secs + 1) % 86400;
      end else begin
        m_presc++;
      end
    end else begin
      m_presc = 0;
      if (rise) begin
        m_ptr = 0;
      end else if (e1) begin
        m_ptr = (m_ptr + 1) % 3;
      end else if (e2) begin
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        se = m_secs % 60;
        case (m_ptr)
          0:       h  = (h + 1) % 24;
          1:       mi = (mi + 1) % 60;
          default: se = (se + 1) % 60;
        endcase
        m_secs = h * 3600 + mi * 60 + se;
      end
    end
    m_pf1 = f1; m_pf2 = f2; m_pmode = md;
  endtask

  task automatic step(input logic r, input logic f1, input logic f2, input logic md);
    RST = r; SW_F1 = f1; SW_F2 = f2; TIMESET_RUN = md;
    @(posedge CLK);
    model_step(r, f1, f2, md);
    #1;
    check("model", obs(), disp(m_secs));
  endtask

  task automatic pulse_f1();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pulse_f2(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic r, f1, f2, md;
    #1;
    // Reset and run
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset", obs(), mk(1'b0, 12, 0, 0));
    repeat (60) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_60", obs(), mk(1'b0, 12, 1, 0));

    // Set minutes from a fresh reset
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_set", obs(), mk(1'b0, 12, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_f1();
    pulse_f2(2);
    check("set_min", obs(), mk(1'b0, 12, 2, 0));
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("frozen", obs(), mk(1'b0, 12, 2, 0));

    // Held button
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("held_f2", obs(), mk(1'b0, 12, 3, 0));

    // Seconds wrap without carry
    pulse_f1();
    pulse_f2(59);
    check("sec_59", obs(), mk(1'b0, 12, 3, 59));
    pulse_f2(1);
    check("sec_wrap", obs(), mk(1'b0, 12, 3, 0));

    // Build 11:59:59 AM then roll over to PM
    pulse_f1();
    pulse_f2(11);
    check("hour_11", obs(), mk(1'b0, 11, 3, 0));
    pulse_f1();
    pulse_f2(56);
    pulse_f1();
    pulse_f2(59);
    check("am_115959", obs(), mk(1'b0, 11, 59, 59));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("to_pm", obs(), mk(1'b1, 12, 0, 0));

    // 12:59:59 PM -> 01:00:00 PM
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_f1();
    pulse_f2(59);
    pulse_f1();
    pulse_f2(59);
    check("pm_125959", obs(), mk(1'b1, 12, 59, 59));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("to_1pm", obs(), mk(1'b1, 1, 0, 0));

    // Simultaneous F1/F2: pointer moves, no increment
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("f1_wins", obs(), mk(1'b1, 1, 0, 0));
    pulse_f2(1);
    check("ptr_min", obs(), mk(1'b1, 1, 1, 0));

    // Mode change with a button press in the same cycle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_1s", obs(), mk(1'b1, 1, 1, 1));
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("mode_btn", obs(), mk(1'b1, 1, 1, 1));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_f2(1);
    check("ptr_hour", obs(), mk(1'b1, 2, 1, 1));

    // Reset with pointer on SEC
    pulse_f1();
    pulse_f1();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_mid", obs(), mk(1'b0, 12, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_f2(1);
    check("reset_ptr", obs(), mk(1'b0, 1, 0, 0));

    // Randomized inputs, model compared every cycle
    md = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      f1 = ($urandom_range(0, 3) == 0);
      f2 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) md = ~md;
      step(r, f1, f2, md);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
